// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver in the system clock domain.
// Raw pins are synchronised and deglitched, 11-bit frames are checked
// (start, 8 data LSB first, odd parity, stop), E0/F0 prefixes fold into
// flags, and decoded codes are queued in a first-word fall-through FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter int EXT_DECODE     = 1
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              PS2_CLK,
    input  logic                              PS2_DAT,
    output logic [7:0]                        CODE_OUT,
    output logic                              CODE_EXT,
    output logic                              CODE_BREAK,
    output logic                              CODE_VALID,
    input  logic                              CODE_READY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT,
    output logic                              FRAME_ERR,
    output logic                              OVERFLOW
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [FW-1:0] FLT_ZERO = FW'(0);
    localparam logic [FW-1:0] FLT_ONE  = FW'(1);
    localparam logic [FW-1:0] FLT_MAX  = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic [1:0]    clk_sync_r;
    logic [1:0]    dat_sync_r;
    logic          clk_filt_r;
    logic          dat_filt_r;
    logic [FW-1:0] clk_cnt_r;
    logic [FW-1:0] dat_cnt_r;
    logic          fall_r;

    state_t        state_r;
    state_t        state_s;
    logic [2:0]    bit_cnt_r;
    logic [2:0]    bit_cnt_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_s;
    logic          par_r;
    logic          par_s;
    logic [TW-1:0] tmo_cnt_r;
    logic          byte_ok_s;
    logic          err_s;
    logic          frame_err_r;

    logic          ext_pend_r;
    logic          brk_pend_r;
    logic          ext_pend_s;
    logic          brk_pend_s;
    logic          push_s;
    logic [9:0]    push_data_s;

    logic [9:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;
    logic          valid_s;
    logic          full_s;
    logic          pop_s;
    logic          wr_en_s;

    // Two-flop synchronisers for both asynchronous pins (idle level is high).
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clk_sync_r <= 2'b11;
            dat_sync_r <= 2'b11;
        end else begin
            clk_sync_r <= {clk_sync_r[0], PS2_CLK};
            dat_sync_r <= {dat_sync_r[0], PS2_DAT};
        end
    end

    // Clock deglitcher; a 1->0 change of the filtered level raises the fall strobe.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clk_filt_r <= 1'b1;
            clk_cnt_r  <= FLT_ZERO;
            fall_r     <= 1'b0;
        end else begin
            fall_r <= 1'b0;
            if (clk_sync_r[1] == clk_filt_r) begin
                clk_cnt_r <= FLT_ZERO;
            end else if (clk_cnt_r == FLT_MAX) begin
                clk_filt_r <= clk_sync_r[1];
                clk_cnt_r  <= FLT_ZERO;
                fall_r     <= clk_filt_r;
            end else begin
                clk_cnt_r <= clk_cnt_r + FLT_ONE;
            end
        end
    end

    // Data deglitcher, same rule as the clock filter.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dat_filt_r <= 1'b1;
            dat_cnt_r  <= FLT_ZERO;
        end else if (dat_sync_r[1] == dat_filt_r) begin
            dat_cnt_r <= FLT_ZERO;
        end else if (dat_cnt_r == FLT_MAX) begin
            dat_filt_r <= dat_sync_r[1];
            dat_cnt_r  <= FLT_ZERO;
        end else begin
            dat_cnt_r <= dat_cnt_r + FLT_ONE;
        end
    end

    // Frame FSM next-state logic: one step per fall strobe, plus timeout abort.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        par_s     = par_r;
        byte_ok_s = 1'b0;
        err_s     = 1'b0;
        if (fall_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (!dat_filt_r) begin
                        state_s   = ST_DATA;
                        bit_cnt_s = 3'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_s = {dat_filt_r, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = ST_PARITY;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_s   = dat_filt_r;
                    state_s = ST_STOP;
                end
                ST_STOP: begin
                    state_s = ST_IDLE;
                    if (odd_parity_ok(shift_r, par_r) && dat_filt_r) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else if ((state_r != ST_IDLE) && (tmo_cnt_r == TMO_MAX)) begin
            state_s = ST_IDLE;
            err_s   = 1'b1;
        end else begin
            state_s = state_r;
        end
    end

    // Frame FSM registers and the one-cycle error pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            par_r       <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            par_r       <= par_s;
            frame_err_r <= err_s;
        end
    end

    // Inactivity counter: held at zero while idle, restarted by each fall strobe.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tmo_cnt_r <= TMO_ZERO;
        end else if (fall_r || (state_r == ST_IDLE)) begin
            tmo_cnt_r <= TMO_ZERO;
        end else if (tmo_cnt_r != TMO_MAX) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Prefix folding: E0/F0 only set flags, any other good byte is queued.
    always_comb begin
        push_s      = 1'b0;
        push_data_s = {ext_pend_r, brk_pend_r, shift_r};
        ext_pend_s  = ext_pend_r;
        brk_pend_s  = brk_pend_r;
        if (err_s) begin
            ext_pend_s = 1'b0;
            brk_pend_s = 1'b0;
        end else if (byte_ok_s) begin
            if ((EXT_DECODE != 0) && (shift_r == 8'hE0)) begin
                ext_pend_s = 1'b1;
            end else if ((EXT_DECODE != 0) && (shift_r == 8'hF0)) begin
                brk_pend_s = 1'b1;
            end else begin
                push_s     = 1'b1;
                ext_pend_s = 1'b0;
                brk_pend_s = 1'b0;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Prefix flag registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
        end else begin
            ext_pend_r <= ext_pend_s;
            brk_pend_r <= brk_pend_s;
        end
    end

    assign valid_s = (count_r != CNT_ZERO);
    assign full_s  = (count_r == CNT_FULL);
    assign pop_s   = valid_s & CODE_READY;
    assign wr_en_s = push_s & (~full_s | pop_s);

    // FIFO storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy and the drop-on-full pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= push_s & full_s & ~pop_s;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation: zeros whenever the FIFO is empty.
    always_comb begin
        CODE_OUT   = 8'h00;
        CODE_EXT   = 1'b0;
        CODE_BREAK = 1'b0;
        if (valid_s) begin
            {CODE_EXT, CODE_BREAK, CODE_OUT} = mem_r[rd_ptr_r];
        end else begin
            {CODE_EXT, CODE_BREAK, CODE_OUT} = 10'h000;
        end
    end

    assign CODE_VALID = valid_s;
    assign FIFO_COUNT = count_r;
    assign FRAME_ERR  = frame_err_r;
    assign OVERFLOW   = overflow_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: two instances (prefix decoding on and off)
// share the PS/2 pins and ready line; a queue-based model predicts every
// popped code, error pulse and overflow pulse.
module tb_ps2_rx_fifo;

    localparam int FL    = 8;
    localparam int TMO   = 1000;
    localparam int DEPTH = 8;
    localparam int HALF  = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic ready = 1'b0;

    logic [7:0] code_d, code_r;
    logic       ext_d, ext_r, brk_d, brk_r, valid_d, valid_r;
    logic [3:0] cnt_d, cnt_r;
    logic       err_d, err_r, ovf_d, ovf_r;

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .EXT_DECODE(1)) dut (
        .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .CODE_OUT(code_d), .CODE_EXT(ext_d), .CODE_BREAK(brk_d), .CODE_VALID(valid_d),
        .CODE_READY(ready), .FIFO_COUNT(cnt_d), .FRAME_ERR(err_d), .OVERFLOW(ovf_d)
    );

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH), .EXT_DECODE(0)) dut_raw (
        .CLK(clk), .RST_N(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .CODE_OUT(code_r), .CODE_EXT(ext_r), .CODE_BREAK(brk_r), .CODE_VALID(valid_r),
        .CODE_READY(ready), .FIFO_COUNT(cnt_r), .FRAME_ERR(err_r), .OVERFLOW(ovf_r)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [9:0] q_dec[$];
    logic [9:0] q_raw[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    int exp_err = 0, exp_ovf_dec = 0, exp_ovf_raw = 0;
    int seen_err_dec = 0, seen_err_raw = 0, seen_ovf_dec = 0, seen_ovf_raw = 0;
    bit rnd_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one received frame for both decoding modes.
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            if (q_raw.size() == DEPTH) exp_ovf_raw++;
            else q_raw.push_back({2'b00, b});
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                if (q_dec.size() == DEPTH) exp_ovf_dec++;
                else q_dec.push_back({m_ext, m_brk, b});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
    endtask

    // Monitor just before each rising edge: count pulses, check every pop.
    always begin
        @(negedge clk);
        #4;
        if (err_d) seen_err_dec++;
        if (err_r) seen_err_raw++;
        if (ovf_d) seen_ovf_dec++;
        if (ovf_r) seen_ovf_raw++;
        if (valid_d && ready) begin
            if (q_dec.size() == 0) check_eq("pop_dec_unexpected", q_dec.size(), 1);
            else check_eq("pop_dec", {ext_d, brk_d, code_d}, q_dec.pop_front());
        end
        if (valid_r && ready) begin
            if (q_raw.size() == 0) check_eq("pop_raw_unexpected", q_raw.size(), 1);
            else check_eq("pop_raw", {ext_r, brk_r, code_r}, q_raw.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        logic par;
        par = par_ok ? ~(^b) : (^b);
        return {stop_ok ? 1'b1 : 1'b0, par, b, 1'b0};
    endfunction

    // Drive nbits of a frame; optionally glitch the clock and/or pop exactly
    // on the edge where the stop bit's code is written.
    task automatic send_frame(input logic [10:0] bits, input int nbits, input bit pop_at_stop,
                              input bit glitch, input logic [7:0] b, input bit ok, input bit do_model);
        int g;
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            g = $urandom_range(1, FL - 1);
            if (glitch) begin
                tick(10); ps2_clk = 1'b0; tick(g); ps2_clk = 1'b1; tick(HALF - 10 - g);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b0;
            if (i == 10 && do_model && !pop_at_stop) model_frame(b, ok);
            if (i == 10 && pop_at_stop) begin
                tick(FL + 2);
                ready = 1'b1;
                tick(1);
                ready = 1'b0;
                if (do_model) model_frame(b, ok);
                tick(HALF - FL - 3);
            end else if (glitch) begin
                tick(10); ps2_clk = 1'b1; tick(g); ps2_clk = 1'b0; tick(HALF - 10 - g);
            end else begin
                tick(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                             input bit pop_at_stop, input bit glitch);
        send_frame(make_frame(b, par_ok, stop_ok), 11, pop_at_stop, glitch, b, par_ok && stop_ok, 1'b1);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_cnt_dec"}, cnt_d, q_dec.size());
        check_eq({tag, "_cnt_raw"}, cnt_r, q_raw.size());
        check_eq({tag, "_valid_dec"}, valid_d, q_dec.size() != 0);
        if (q_dec.size() != 0) check_eq({tag, "_head_dec"}, {ext_d, brk_d, code_d}, q_dec[0]);
        else check_eq({tag, "_head_dec_empty"}, {ext_d, brk_d, code_d}, 0);
        if (q_raw.size() != 0) check_eq({tag, "_head_raw"}, {ext_r, brk_r, code_r}, q_raw[0]);
        else check_eq({tag, "_head_raw_empty"}, {ext_r, brk_r, code_r}, 0);
        check_eq({tag, "_err_dec"}, seen_err_dec, exp_err);
        check_eq({tag, "_err_raw"}, seen_err_raw, exp_err);
        check_eq({tag, "_ovf_dec"}, seen_ovf_dec, exp_ovf_dec);
        check_eq({tag, "_ovf_raw"}, seen_ovf_raw, exp_ovf_raw);
    endtask

    task automatic drain(input string tag);
        ready = 1'b1;
        tick(2 * DEPTH + 4);
        ready = 1'b0;
        tick(2);
        check_state(tag);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached with checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit ok, which;

        // Reset values.
        rst_n = 1'b0;
        tick(4);
        check_eq("rst_valid", valid_d, 0);
        check_eq("rst_code", {ext_d, brk_d, code_d}, 0);
        check_eq("rst_count", cnt_d, 0);
        check_eq("rst_err", err_d, 0);
        check_eq("rst_ovf", ovf_d, 0);
        check_eq("rst_count_raw", cnt_r, 0);
        rst_n = 1'b1;
        tick(5);

        // Single good frame, consumer not ready.
        send_byte(8'h1C, 1, 1, 0, 0);
        check_eq("t1_valid", valid_d, 1);
        check_eq("t1_code", code_d, 8'h1C);
        check_eq("t1_flags", {ext_d, brk_d}, 0);
        check_eq("t1_count", cnt_d, 1);
        check_state("t1");
        drain("t1_drain");

        // Extended break sequence; raw instance keeps every byte.
        send_byte(8'hE0, 1, 1, 0, 0);
        send_byte(8'hF0, 1, 1, 0, 0);
        send_byte(8'h75, 1, 1, 0, 0);
        send_byte(8'h6B, 1, 1, 0, 0);
        check_eq("t2_count_dec", cnt_d, 2);
        check_eq("t2_count_raw", cnt_r, 4);
        check_eq("t2_head_dec", {ext_d, brk_d, code_d}, 10'h375);
        check_eq("t2_head_raw", code_r, 8'hE0);
        check_state("t2");
        drain("t2_drain");

        // Parity error, stop error, then a good frame.
        send_byte(8'h1C, 0, 1, 0, 0);
        check_state("t3_par");
        send_byte(8'h1C, 1, 0, 0, 0);
        check_state("t3_stop");
        send_byte(8'h2D, 1, 1, 0, 0);
        check_eq("t3_good", code_d, 8'h2D);
        check_state("t3_good");
        drain("t3_drain");

        // Partial frame then silence: timeout abort.
        send_frame(make_frame(8'h55, 1, 1), 5, 0, 0, 8'h00, 0, 0);
        tick(TMO + 100);
        exp_err++;
        check_state("t4_tmo");
        send_byte(8'h76, 1, 1, 0, 0);
        check_eq("t4_code", code_d, 8'h76);
        check_state("t4_after");
        drain("t4_drain");

        // Fill past capacity, then a push coinciding with a pop while full.
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'h10 + 8'(i);
            send_byte(b, 1, 1, 0, 0);
        end
        check_eq("t5_count", cnt_d, DEPTH);
        check_eq("t5_ovf_seen", seen_ovf_dec, 1);
        check_eq("t5_head", code_d, 8'h10);
        check_state("t5_full");
        send_byte(8'h3A, 1, 1, 1, 0);
        check_eq("t5_count_pp", cnt_d, DEPTH);
        check_eq("t5_ovf_pp", seen_ovf_dec, 1);
        check_state("t5_pushpop");
        drain("t5_drain");

        // Glitches shorter than the filter length on the clock pin.
        send_byte(8'h74, 1, 1, 0, 1);
        check_eq("t6_code", code_d, 8'h74);
        check_state("t6");
        drain("t6_drain");

        // Reset mid-frame with data queued and a prefix pending.
        send_byte(8'h11, 1, 1, 0, 0);
        send_byte(8'hE0, 1, 1, 0, 0);
        send_frame(make_frame(8'h5A, 1, 1), 6, 0, 0, 8'h00, 0, 0);
        rst_n = 1'b0;
        tick(3);
        q_dec.delete();
        q_raw.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_eq("t7_rst_count", cnt_d, 0);
        check_eq("t7_rst_out", {valid_d, ext_d, brk_d, code_d}, 0);
        rst_n = 1'b1;
        tick(5);
        send_byte(8'h29, 1, 1, 0, 0);
        check_eq("t7_code", {ext_d, brk_d, code_d}, 10'h029);
        check_state("t7");
        drain("t7_drain");

        // Randomized traffic with a randomly stalling consumer.
        rnd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
            ok = ($urandom_range(0, 9) != 0);
            which = 1'($urandom_range(0, 1));
            send_byte(b, ok || which, ok || !which, 0, 0);
        end
        rnd_ready = 1'b0;
        ready = 1'b0;
        drain("t8_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
